// File: rtl/sorter_stream_ctrl.sv
// Streaming wrapper around a combinational 8-input sorter: serial bytes in,
// one full frame presented to the sorter, sorted bytes streamed back out.
module sorter_stream_ctrl #(
  parameter int W           = 8,
  parameter int N           = 8,
  parameter int DRAIN_ORDER = 0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [W-1:0]   in_data,
  input  logic           in_valid,
  output logic           in_ready,
  output logic [N*W-1:0] srt_a,
  input  logic [N*W-1:0] srt_y,
  output logic [W-1:0]   out_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic           out_last,
  output logic           busy
);

  if (N != 8) begin : g_n_check
    $error("sorter_stream_ctrl: N must be 8");
  end

  typedef enum logic [1:0] {FILL, SORT, DRAIN} state_t;

  state_t       state, state_next;
  logic [2:0]   fill_cnt, drain_cnt, drain_idx;
  logic [W-1:0] frame_p0 [N];
  logic [W-1:0] res_p1   [N];
  logic         in_fire, out_fire;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= FILL;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b1;
    case (state)
      FILL: begin
        in_ready = ~rst;
        busy     = 1'b0;
        if (in_fire && fill_cnt == 3'd7) state_next = SORT;
      end
      SORT: state_next = DRAIN;
      DRAIN: begin
        out_valid = 1'b1;
        if (out_fire && drain_cnt == 3'd7) state_next = FILL;
      end
      default: state_next = FILL;
    endcase
  end

  // Counters wrap 7 -> 0 on the terminal handshake, which also ends the phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      fill_cnt  <= 3'd0;
      drain_cnt <= 3'd0;
    end else begin
      if (in_fire) fill_cnt <= fill_cnt + 3'd1;
      if (state == SORT)  drain_cnt <= 3'd0;
      else if (out_fire)  drain_cnt <= drain_cnt + 3'd1;
    end
  end

  // Stage p0: frame assembly, frozen outside FILL so srt_a is stable for the sorter.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) frame_p0[i] <= '0;
    end else if (in_fire) begin
      frame_p0[fill_cnt] <= in_data;
    end
  end

  always_comb begin
    srt_a = '0;
    for (int i = 0; i < N; i++) srt_a[i*W +: W] = frame_p0[i];
  end

  // Stage p1: sorter result captured during the single SORT cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) res_p1[i] <= '0;
    end else if (state == SORT) begin
      for (int i = 0; i < N; i++) res_p1[i] <= srt_y[i*W +: W];
    end
  end

  assign drain_idx = (DRAIN_ORDER != 0) ? (3'd7 - drain_cnt) : drain_cnt;
  assign out_data  = res_p1[drain_idx];
  assign out_last  = out_valid & (drain_cnt == 3'd7);

endmodule
